// File: rtl/prio_grant_encoder.sv
// prio_grant_encoder
//   Registered N-way priority / round-robin grant encoder with a valid/ack
//   handshake. A grant, once presented, is held unchanged until it is
//   accepted (valid & ack). On acceptance the round-robin pointer advances
//   past the granted index and the same-cycle request vector is
//   re-arbitrated, so a continuously acked stream gets one grant per cycle.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   [N-1:0] level request vector
//   ack     in   consumer accepts the presented grant (ignored while !valid)
//   valid   out  grant present
//   code    out  [W-1:0] binary index of granted request
//   onehot  out  [N-1:0] one-hot grant, zero while !valid
module prio_grant_encoder #(
    parameter int N  = 8,
    parameter int RR = 0,
    parameter int W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] onehot
);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_upd;
    logic [W-1:0] sptr;
    logic [W-1:0] win_hi;
    logic [W-1:0] win_lo;
    logic [W-1:0] win;
    logic         any_hi;
    logic [N-1:0] win_oh;
    logic         xfer;

    assign xfer = valid & ack;

    // Next search start after a transfer. The wrap is an explicit compare
    // against N-1 so a non-power-of-two N never yields an index >= N.
    always_comb begin
        ptr_upd = '0;
        if (RR != 0) begin
            ptr_upd = (code == W'(N - 1)) ? '0 : code + 1'b1;
        end
    end

    // A transfer re-arbitrates with the pointer it is about to store.
    assign sptr = xfer ? ptr_upd : ptr;

    // Circular search from sptr: the lowest set index at or above sptr wins;
    // if none, the lowest set index overall (the wrapped part) wins.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        any_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_lo = W'(i);
                if (W'(i) >= sptr) begin
                    win_hi = W'(i);
                    any_hi = 1'b1;
                end
            end
        end
    end

    assign win = any_hi ? win_hi : win_lo;

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N; i++) begin
            win_oh[i] = (W'(i) == win);
        end
    end

    // valid encodes the FSM: 0 = IDLE, 1 = GRANT. A held grant ignores req.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            code   <= '0;
            onehot <= '0;
            ptr    <= '0;
        end else if (!valid || ack) begin
            if (xfer) begin
                ptr <= ptr_upd;
            end
            if (|req) begin
                valid  <= 1'b1;
                code   <= win;
                onehot <= win_oh;
            end else begin
                valid  <= 1'b0;
                onehot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_grant_encoder.sv
module tb_prio_grant_encoder;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut 0: N=8 fixed, dut 1: N=8 round-robin, dut 2: N=5 round-robin
    logic       rst0, rst1, rst2;
    logic [7:0] req0, req1;
    logic [4:0] req2;
    logic       ack0, ack1, ack2;
    logic       v0, v1, v2;
    logic [2:0] c0, c1, c2;
    logic [7:0] oh0, oh1;
    logic [4:0] oh2;

    prio_grant_encoder #(.N(8), .RR(0)) u0 (.clk(clk), .rst(rst0), .req(req0), .ack(ack0),
                                            .valid(v0), .code(c0), .onehot(oh0));
    prio_grant_encoder #(.N(8), .RR(1)) u1 (.clk(clk), .rst(rst1), .req(req1), .ack(ack1),
                                            .valid(v1), .code(c1), .onehot(oh1));
    prio_grant_encoder #(.N(5), .RR(1)) u2 (.clk(clk), .rst(rst2), .req(req2), .ack(ack2),
                                            .valid(v2), .code(c2), .onehot(oh2));

    typedef struct {
        int         dut;
        string      name;
        logic       v;
        logic [2:0] c;
        logic [7:0] oh;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show after the edge.
    task automatic step(input int d, input string name, input logic r, input logic [7:0] rq,
                        input logic a, input logic ev, input logic [2:0] ec, input logic [7:0] eoh);
        exp_t e;
        @(negedge clk);
        #2;
        case (d)
            0: begin rst0 = r; req0 = rq; ack0 = a; end
            1: begin rst1 = r; req1 = rq; ack1 = a; end
            default: begin rst2 = r; req2 = rq[4:0]; ack2 = a; end
        endcase
        e.dut = d; e.name = name; e.v = ev; e.c = ec; e.oh = eoh;
        q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge.
    initial begin
        exp_t       e;
        logic       av;
        logic [2:0] ac;
        logic [7:0] aoh;
        logic [7:0] one;
        one = 8'd1;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                case (e.dut)
                    0: begin av = v0; ac = c0; aoh = oh0; end
                    1: begin av = v1; ac = c1; aoh = oh1; end
                    default: begin av = v2; ac = c2; aoh = {3'b000, oh2}; end
                endcase
                chk({e.name, ".valid"}, {7'd0, av}, {7'd0, e.v});
                if (e.v) chk({e.name, ".code"}, {5'd0, ac}, {5'd0, e.c});
                chk({e.name, ".onehot"}, aoh, e.oh);
                if (av === 1'b1) chk({e.name, ".inv"}, aoh, one << ac);
            end
        end
    end

    initial begin
        rst0 = 1'b1; req0 = 8'hFF; ack0 = 1'b1;
        rst1 = 1'b1; req1 = 8'h00; ack1 = 1'b0;
        rst2 = 1'b1; req2 = 5'h00; ack2 = 1'b0;

        // 1. reset overrides req/ack, then first free edge grants index 0
        step(0, "rst",     1, 8'hFF, 1, 0, 0, 8'h00);
        step(0, "rst",     1, 8'hFF, 1, 0, 0, 8'h00);
        step(0, "rst_rel", 0, 8'hFF, 0, 1, 0, 8'h01);

        // 2. fixed priority, sticky hold
        step(0, "drain0",  0, 8'h00, 1, 0, 0, 8'h00);
        step(0, "fix_a4",  0, 8'hA4, 0, 1, 2, 8'h04);
        for (int i = 0; i < 3; i++) step(0, "fix_hold", 0, 8'h01, 0, 1, 2, 8'h04);
        step(0, "fix_ack", 0, 8'h01, 1, 1, 0, 8'h01);
        step(0, "fix_hd0", 0, 8'h01, 0, 1, 0, 8'h01);

        // 3. fixed starvation: 5 and 7 never granted
        for (int i = 0; i < 6; i++) step(0, "starve", 0, 8'hA4, 1, 1, 2, 8'h04);
        step(0, "drain1",  0, 8'h00, 1, 0, 0, 8'h00);

        // 4. round-robin sweep, one grant per cycle
        for (int i = 0; i < 10; i++) begin
            logic [2:0] k;
            k = 3'(i % 8);
            step(1, "rr_sweep", 0, 8'hFF, 1, 1, k, 8'h01 << k);
        end
        step(1, "rr_drain", 0, 8'h00, 1, 0, 0, 8'h00);
        step(1, "ack_idle", 0, 8'h00, 1, 0, 0, 8'h00);

        // 5. N=5 wrap: 0,4,0,4 then ptr wraps to 0 and bit 1 wins
        step(2, "w5",      0, 8'h11, 1, 1, 0, 8'h01);
        step(2, "w5",      0, 8'h11, 1, 1, 4, 8'h10);
        step(2, "w5",      0, 8'h11, 1, 1, 0, 8'h01);
        step(2, "w5",      0, 8'h11, 1, 1, 4, 8'h10);
        step(2, "w5_b1",   0, 8'h02, 1, 1, 1, 8'h02);
        step(2, "w5_hold", 0, 8'h02, 0, 1, 1, 8'h02);
        step(2, "w5_b4",   0, 8'h1A, 1, 1, 3, 8'h08);
        step(2, "w5_b4b",  0, 8'h1A, 1, 1, 4, 8'h10);
        step(2, "w5_wrap", 0, 8'h1A, 1, 1, 1, 8'h02);

        // 6. drain and reset mid-grant (ptr is 2 after the sweep)
        step(1, "single3", 0, 8'h08, 0, 1, 3, 8'h08);
        step(1, "drain3",  0, 8'h00, 1, 0, 0, 8'h00);
        step(1, "regnt6",  0, 8'h40, 0, 1, 6, 8'h40);
        step(1, "midrst",  1, 8'h40, 0, 0, 0, 8'h00);
        step(1, "ptr0",    0, 8'h41, 0, 1, 0, 8'h01);
        step(1, "ptr0_hd", 0, 8'h41, 0, 1, 0, 8'h01);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
